// File: rtl/ysyx_25030093_ifu_fetch.sv
// Multi-cycle instruction fetch: one outstanding memory read per instruction,
// result held for the IDU until accepted, then waits for the next PC.
module ysyx_25030093_ifu_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    input  logic              mem_rsp_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       out_inst,
    output logic              out_fault,
    input  logic              npc_valid,
    input  logic [ADDR_W-1:0] npc
);

    localparam logic [1:0]  S_REQ  = 2'd0;
    localparam logic [1:0]  S_WAIT = 2'd1;
    localparam logic [1:0]  S_HOLD = 2'd2;
    localparam logic [1:0]  S_NPC  = 2'd3;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_live;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_pc;
    logic [31:0]       r_out_inst;
    logic              r_out_fault;

    logic              w_misaligned;
    logic              w_req_valid;

    // Request decode; r_live keeps the port quiet in the first cycle out of reset.
    always_comb begin
        w_misaligned = 1'b0;
        w_req_valid  = 1'b0;
        if (r_pc[1:0] != 2'b00) begin
            w_misaligned = 1'b1;
        end else begin
            w_misaligned = 1'b0;
        end
        if ((r_state == S_REQ) && r_live && !w_misaligned) begin
            w_req_valid = 1'b1;
        end else begin
            w_req_valid = 1'b0;
        end
    end

    assign mem_req_valid = w_req_valid;
    assign mem_req_addr  = r_pc;
    assign out_valid     = r_out_valid;
    assign out_pc        = r_out_pc;
    assign out_inst      = r_out_inst;
    assign out_fault     = r_out_fault;

    // Fetch sequencer: PC, state and the registered IDU-facing outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_live      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_pc    <= RESET_PC;
            r_out_inst  <= 32'h0000_0000;
            r_out_fault <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                S_REQ: begin
                    // A misaligned PC never reaches memory; it is reported as a faulting nop.
                    if (r_live && w_misaligned) begin
                        r_out_valid <= 1'b1;
                        r_out_pc    <= r_pc;
                        r_out_inst  <= NOP;
                        r_out_fault <= 1'b1;
                        r_state     <= S_HOLD;
                    end else if (w_req_valid && mem_req_ready) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_state <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_pc    <= r_pc;
                        r_out_inst  <= mem_rsp_err ? NOP : mem_rsp_data;
                        r_out_fault <= mem_rsp_err;
                        r_state     <= S_HOLD;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (npc_valid) begin
                            r_pc    <= npc;
                            r_state <= S_REQ;
                        end else begin
                            r_state <= S_NPC;
                        end
                    end else begin
                        r_state <= S_HOLD;
                    end
                end
                S_NPC: begin
                    if (npc_valid) begin
                        r_pc    <= npc;
                        r_state <= S_REQ;
                    end else begin
                        r_state <= S_NPC;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25030093_ifu_fetch.sv
// Directed table-driven bench for the fetch stage, plus a reset-during-WAIT sequence.
module tb_ysyx_25030093_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;
    logic        npc_valid;
    logic [31:0] npc;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;

    typedef struct {
        logic [31:0] addr;
        int          rdy_dly;
        int          rsp_dly;
        logic [31:0] data;
        logic        err;
        int          stall;
        logic [31:0] npc;
        logic        npc_same;
        logic [31:0] exp_inst;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[6];
    vec_t vr;

    ysyx_25030093_ifu_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_err   (mem_rsp_err),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_inst      (out_inst),
        .out_fault     (out_fault),
        .npc_valid     (npc_valid),
        .npc           (npc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req_valid && mem_req_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Entry: at a negedge with the DUT in REQ. Exit: at the negedge where out_valid should be 1.
    task automatic do_fetch(input vec_t v);
        int a0;
        a0 = acc_cnt;
        chk("entry_no_out", 32'(out_valid), 32'd0);
        if (v.addr[1:0] != 2'b00) begin
            chk("mis_no_req", 32'(mem_req_valid), 32'd0);
            step();
        end else begin
            chk("req_valid", 32'(mem_req_valid), 32'd1);
            chk("req_addr", mem_req_addr, v.addr);
            for (int i = 0; i < v.rdy_dly; i++) begin
                mem_req_ready = 1'b0;
                step();
                chk("req_hold_valid", 32'(mem_req_valid), 32'd1);
                chk("req_hold_addr", mem_req_addr, v.addr);
            end
            mem_req_ready = 1'b1;
            step();
            mem_req_ready = 1'b0;
            chk("wait_no_req", 32'(mem_req_valid), 32'd0);
            chk("wait_no_out", 32'(out_valid), 32'd0);
            for (int i = 0; i < v.rsp_dly; i++) begin
                npc_valid = 1'b1;
                npc       = 32'h1111_1110;
                step();
                chk("wait_rsp_no_out", 32'(out_valid), 32'd0);
            end
            npc_valid     = 1'b0;
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = v.data;
            mem_rsp_err   = v.err;
            step();
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'h0;
            mem_rsp_err   = 1'b0;
        end
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_pc", out_pc, v.addr);
        chk("out_inst", out_inst, v.exp_inst);
        chk("out_fault", 32'(out_fault), 32'(v.exp_fault));
        chk("req_accepted", 32'(acc_cnt - a0), (v.addr[1:0] != 2'b00) ? 32'd0 : 32'd1);
    endtask

    // Entry: out_valid=1. Exit: at a negedge with the DUT back in REQ at v.npc.
    task automatic handoff(input vec_t v);
        for (int i = 0; i < v.stall; i++) begin
            out_ready = 1'b0;
            step();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_pc", out_pc, v.addr);
            chk("hold_inst", out_inst, v.exp_inst);
            chk("hold_fault", 32'(out_fault), 32'(v.exp_fault));
        end
        out_ready = 1'b1;
        if (v.npc_same) begin
            npc_valid = 1'b1;
            npc       = v.npc;
        end
        step();
        out_ready = 1'b0;
        chk("drop_valid", 32'(out_valid), 32'd0);
        if (!v.npc_same) begin
            chk("npc_no_req", 32'(mem_req_valid), 32'd0);
            npc_valid = 1'b1;
            npc       = v.npc;
            step();
        end
        npc_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h8000_0000, 0, 0, 32'h0000_0413, 1'b0, 0, 32'h8000_0004, 1'b1, 32'h0000_0413, 1'b0};
        vecs[1] = '{32'h8000_0004, 3, 0, 32'h0010_0093, 1'b0, 5, 32'h8000_0008, 1'b1, 32'h0010_0093, 1'b0};
        vecs[2] = '{32'h8000_0008, 0, 2, 32'h0020_8113, 1'b0, 0, 32'h8000_0002, 1'b0, 32'h0020_8113, 1'b0};
        vecs[3] = '{32'h8000_0002, 0, 0, 32'h0000_0000, 1'b0, 2, 32'h8000_000C, 1'b1, 32'h0000_0013, 1'b1};
        vecs[4] = '{32'h8000_000C, 1, 1, 32'hDEAD_BEEF, 1'b1, 0, 32'h8000_0010, 1'b0, 32'h0000_0013, 1'b1};
        vecs[5] = '{32'h8000_0010, 0, 0, 32'h1234_5678, 1'b0, 1, 32'h8000_0014, 1'b1, 32'h1234_5678, 1'b0};
        vr      = '{32'h8000_0000, 0, 0, 32'h0000_0413, 1'b0, 0, 32'h8000_0004, 1'b1, 32'h0000_0413, 1'b0};

        rst           = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        mem_rsp_err   = 1'b0;
        out_ready     = 1'b0;
        npc_valid     = 1'b0;
        npc           = 32'h0;

        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_out_pc", out_pc, 32'h8000_0000);
        chk("rst_out_fault", 32'(out_fault), 32'd0);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        rst = 1'b1;
        step();

        for (int k = 0; k < 6; k++) begin
            do_fetch(vecs[k]);
            handoff(vecs[k]);
        end

        // Reset while a response is pending, then a stale response right after release.
        chk("mid_req_addr", mem_req_addr, 32'h8000_0014);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("mid_wait_no_req", 32'(mem_req_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("mid_rst_out_pc", out_pc, 32'h8000_0000);
        chk("mid_rst_out_inst", out_inst, 32'h0);
        chk("mid_rst_req_addr", mem_req_addr, 32'h8000_0000);
        step();
        rst           = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0BAD_BAD0;
        step();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        chk("stale_no_out", 32'(out_valid), 32'd0);
        do_fetch(vr);
        handoff(vr);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
